vga_timing_gen: RTL and testbench

- Generates VGA raster timing for the ZEOWAA board's display interface: hsync, vsync and the 1-bit red/green/blue lines.
- Sits directly upstream of the display interface. It supplies pixel coordinates and a pixel strobe to the game/render logic.
- It samples the render logic's colour, blanks it outside the active area, and registers colour and syncs together so they stay aligned at the pins.

---
 rtl/vga_timing_gen_if.sv | 30 +++
 rtl/vga_timing_gen.sv | 102 ++++++++++
 tb/tb_vga_timing_gen.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle between the VGA timing generator and the render logic / pins.
// The generator drives timing, coordinates and pin outputs; the render side drives rgb_in.
interface vga_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          pix_tick;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_visible;
  logic          frame_start;
  logic [2:0]    rgb_in;
  logic          red;
  logic          green;
  logic          blue;
  logic          hsync;
  logic          vsync;

  modport master (
    output pix_tick, pix_x, pix_y, pix_visible, frame_start,
    output red, green, blue, hsync, vsync,
    input  rgb_in
  );

  modport slave (
    input  pix_tick, pix_x, pix_y, pix_visible, frame_start,
    input  red, green, blue, hsync, vsync,
    output rgb_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters, and a registered output stage
// that keeps blanked colour and syncs aligned one pixel behind the counters.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int CLK_DIV  = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int XW       = $clog2(H_TOTAL);
  localparam int YW       = $clog2(V_TOTAL);
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = H_ACTIVE + H_FRONT + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = V_ACTIVE + V_FRONT + V_SYNC;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [2:0]    rgb_q, rgb_d;

  logic pix_tick;
  logic pix_visible;
  logic hsync_act;
  logic vsync_act;

  // Window compares done in int so an end bound equal to the total cannot overflow the counter width.
  assign pix_tick    = (div_cnt_q == DIV_LAST);
  assign pix_visible = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
  assign hsync_act   = (int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_END);
  assign vsync_act   = (int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_END);

  always_comb begin
    div_cnt_d = div_cnt_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    rgb_d     = rgb_q;
    if (pix_tick) begin
      div_cnt_d = '0;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
      hsync_d = hsync_act ? SYNC_POL : ~SYNC_POL;
      vsync_d = vsync_act ? SYNC_POL : ~SYNC_POL;
      rgb_d   = pix_visible ? vga.rgb_in : 3'b000;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      rgb_q     <= 3'b000;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vga.pix_tick    = pix_tick;
  assign vga.pix_x       = h_cnt_q;
  assign vga.pix_y       = v_cnt_q;
  assign vga.pix_visible = pix_visible;
  assign vga.frame_start = pix_tick && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign vga.red         = rgb_q[2];
  assign vga.green       = rgb_q[1];
  assign vga.blue        = rgb_q[0];
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two shrunken-raster instances (CLK_DIV=3 active-low syncs,
// CLK_DIV=1 active-high syncs) against an arithmetic model driven by elapsed clocks.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam int NCYC = 2400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.XW(XW), .YW(YW)) u_if0 ();
  vga_timing_gen_if #(.XW(XW), .YW(YW)) u_if1 ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(3), .SYNC_POL(1'b0)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .vga(u_if0));

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(1), .SYNC_POL(1'b1)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .vga(u_if1));

  int checks = 0;
  int errors = 0;

  // Model state per instance: clocks elapsed since reset, plus last-latched pin values.
  int       cdiv [2] = '{3, 1};
  bit       pol  [2] = '{1'b0, 1'b1};
  int       n    [2];
  logic [2:0] exp_rgb [2];
  logic       exp_hs  [2];
  logic       exp_vs  [2];
  int       cyc = 0;
  int       last_fs = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int m_h(int k);
    return (n[k] / cdiv[k]) % HT;
  endfunction

  function automatic int m_v(int k);
    return (n[k] / cdiv[k] / HT) % VT;
  endfunction

  function automatic bit m_tick(int k);
    return (n[k] % cdiv[k]) == cdiv[k] - 1;
  endfunction

  function automatic bit m_vis(int k);
    return (m_h(k) < HA) && (m_v(k) < VA);
  endfunction

  task automatic check_dut(input int k, input logic tick, input logic [XW-1:0] x,
                           input logic [YW-1:0] y, input logic vis, input logic fs,
                           input logic [2:0] rgb, input logic hs, input logic vs);
    string p;
    bit    efs;
    p   = (k == 0) ? "d0" : "d1";
    efs = m_tick(k) && m_h(k) == 0 && m_v(k) == 0;
    chk({p, "_tick"}, 32'(tick), 32'(m_tick(k)));
    chk({p, "_x"}, 32'(x), 32'(m_h(k)));
    chk({p, "_y"}, 32'(y), 32'(m_v(k)));
    chk({p, "_vis"}, 32'(vis), 32'(m_vis(k)));
    chk({p, "_fs"}, 32'(fs), 32'(efs));
    chk({p, "_rgb"}, 32'(rgb), 32'(exp_rgb[k]));
    chk({p, "_hs"}, 32'(hs), 32'(exp_hs[k]));
    chk({p, "_vs"}, 32'(vs), 32'(exp_vs[k]));
  endtask

  // Advance the model across one rising edge given the inputs the DUT will sample there.
  task automatic step_model(input int k, input logic rn, input logic [2:0] rgb);
    int h, v;
    if (!rn) begin
      n[k]       = 0;
      exp_rgb[k] = 3'b000;
      exp_hs[k]  = ~pol[k];
      exp_vs[k]  = ~pol[k];
    end else begin
      if (m_tick(k)) begin
        h = m_h(k);
        v = m_v(k);
        exp_rgb[k] = m_vis(k) ? rgb : 3'b000;
        exp_hs[k]  = (h >= HA + HF && h < HA + HF + HS) ? pol[k] : ~pol[k];
        exp_vs[k]  = (v >= VA + VF && v < VA + VF + VS) ? pol[k] : ~pol[k];
      end
      n[k]++;
    end
  endtask

  initial begin
    logic       rn_next;
    logic [2:0] rgb0, rgb1;
    for (int k = 0; k < 2; k++) begin
      n[k] = 0; exp_rgb[k] = 3'b000; exp_hs[k] = ~pol[k]; exp_vs[k] = ~pol[k];
    end
    u_if0.rgb_in = 3'b000;
    u_if1.rgb_in = 3'b000;
    rst_n = 1'b0;
    @(posedge clk);
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_dut(0, u_if0.pix_tick, u_if0.pix_x, u_if0.pix_y, u_if0.pix_visible,
                u_if0.frame_start, {u_if0.red, u_if0.green, u_if0.blue},
                u_if0.hsync, u_if0.vsync);
      check_dut(1, u_if1.pix_tick, u_if1.pix_x, u_if1.pix_y, u_if1.pix_visible,
                u_if1.frame_start, {u_if1.red, u_if1.green, u_if1.blue},
                u_if1.hsync, u_if1.vsync);
      if (u_if0.frame_start && rst_n) begin
        if (last_fs >= 0) chk("d0_fs_period", 32'(cyc - last_fs), 32'(HT * VT * cdiv[0]));
        last_fs = cyc;
      end

      rn_next = !(cyc < 3 || cyc == 700 || cyc == 1300 || $urandom_range(0, 799) == 0);
      if (!rn_next) last_fs = -1;
      rgb0 = (cyc < 600) ? 3'b111 : ((cyc < 1300) ? 3'b101 : 3'($urandom_range(0, 7)));
      rgb1 = {3{1'(m_h(1) ^ m_v(1))}};
      rst_n        = rn_next;
      u_if0.rgb_in = rgb0;
      u_if1.rgb_in = rgb1;
      step_model(0, rn_next, rgb0);
      step_model(1, rn_next, rgb1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
